mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter sharing the single-cycle `memory` unit between the instruction-fetch path and the load/store path. It grants at most one access per cycle and issues it to `memory`. It routes the registered result back to the owning requester one cycle later. It also suppresses side-effecting stores that `memory` would fault on, so a faulting access never changes memory contents.

## Interface
- `STARVE_LIMIT`, default 4: maximum consecutive data grants while a fetch is pending before fetch is forced. Legal range is 1..255.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `if_req_valid` in 1: fetch request present.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_req_addr` in 32: fetch address; fetch is always a word load (op 3'b010).
- `if_resp_valid` out 1: fetch response present.
- `if_resp_data` out 32: fetched word.
- `if_resp_fault` out 1: fetch faulted.
- `d_req_valid` in 1: data request present.
- `d_req_ready` out 1: data request accepted this cycle.
- `d_req_op` in 3: bit 2 is store; bits [1:0] are size (00 byte, 01 half, 10 word, 11 invalid).
- `d_req_addr` in 32: data address.
- `d_req_wdata` in 32: store data.
- `d_resp_valid` out 1: data response or store completion present.
- `d_resp_data` out 32: load data, zero-extended; 0 for stores.
- `d_resp_fault` out 1: data access faulted.
- `mem_op` out 3: op to `memory`.
- `mem_addr` out 32: address to `memory`.
- `mem_in` out 32: write data to `memory`.
- `mem_out` in 32: registered read data from `memory`.
- `mem_fault` in 1: registered fault from `memory`.

## Operation
- Requests use a valid/ready handshake.
  - A request transfers in a cycle with valid and ready both high.
  - The requester holds valid, op, addr and wdata stable until ready.
  - Ready is combinational from both valids and the starvation counter.
  - No request is accepted while `reset` is high.
- Arbitration:
  - Data has priority by default.
  - Fetch wins when `d_req_valid` is low.
  - Fetch also wins when `starve_cnt == STARVE_LIMIT` and `if_req_valid` is high.
  - Exactly one ready is high whenever any valid is high; both are low otherwise.
- `starve_cnt` (8 bits, saturating at `STARVE_LIMIT`):
  - +1 in cycles where data is granted while `if_req_valid` is high.
  - Cleared when fetch is granted or when `if_req_valid` is low.
- Memory drive, combinational from the grant:
  - Fetch granted: op 3'b010, addr `if_req_addr`, in 0.
  - Data granted: op `d_req_op`, addr `d_req_addr`, in `d_req_wdata`.
  - Idle: op 3'b000, addr 0, in 0. This harmless byte load is ignored.
- Store suppression: the arbiter replaces `mem_op` with 3'b011 (invalid load; `memory` faults without writing) when a data request has either:
  - size 11 with store bit set; or
  - a misaligned store address (half with addr[0]=1, or word with addr[1:0]≠0).
- Response tracking:
  - Registered `resp_valid_q` and `resp_owner_q` (0 = fetch, 1 = data) are loaded on each grant and cleared on idle.
  - Next cycle, the owner's `*_resp_valid` is 1.
  - `*_resp_fault` = `mem_fault`.
  - `*_resp_data` = `mem_out`, forced to 0 if a fault occurred or the op was a store. A registered `resp_store_q` is kept for this.
  - The non-owner's response outputs are all 0.

## Timing
- Reset values: `resp_valid_q` 0, `resp_owner_q` 0, `resp_store_q` 0, `starve_cnt` 0. All `*_resp_*` outputs read 0 during and after reset until the first grant.
- Latency: a request accepted in cycle N responds in cycle N+1. There is no backpressure on responses.
- Throughput is one access per cycle, with back-to-back grants fully pipelined.
- Alternating grants are legal: the cycle N+1 response belongs to the N grant while the N+1 grant is being issued.
- Reset asserted while a response is pending drops that response. A stale `mem_fault` after reset is ignored.
- With `STARVE_LIMIT`=L and continuous data traffic plus a pending fetch, fetch is granted on the (L+1)th cycle.

## Configuration
- `MEM_ARBITER_STATS_EN` defined: adds three 32-bit wrapping counters as outputs, all reset to 0.
  - `stat_if_grants`: +1 per fetch grant.
  - `stat_d_grants`: +1 per data grant.
  - `stat_if_stalls`: +1 per cycle with `if_req_valid` high and `if_req_ready` low.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Fetch only, addr 0x10, memory word 0x11223344 → `mem_op` 3'b010 in cycle N; in N+1, `if_resp_valid`=1, data 0x11223344, fault 0.
- Both valid continuously, `STARVE_LIMIT`=4 → data granted 4 cycles, fetch granted cycle 5, `starve_cnt` back to 0; pattern repeats.
- Data SW addr 0x22 data 0xDEADBEEF → `mem_op` 3'b011; in N+1, `d_resp_fault`=1, data 0. A following LW at 0x20 returns the unchanged prior contents.
- Data LB at 0x05 (byte 0xA5) then SH 0x1234 at 0x06 back-to-back → responses in N+1 (0x000000A5) and N+2 (0, fault 0). Bytes 0x06/0x07 read back 0x34/0x12.
- Data op 3'b111 → `mem_op` 3'b011; `d_resp_fault`=1; no memory byte changes.
- Reset pulse in cycle N+1 after a grant in N → `d_resp_valid` stays 0; `starve_cnt` is 0 after reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-cycle memory port between instruction fetch
// and load/store traffic. Data has priority, with a starvation limit that
// forces a fetch grant after STARVE_LIMIT consecutive data wins. Stores that
// the memory would fault on are rewritten to an invalid load (op 3'b011) so a
// faulting access never changes memory contents. Responses come back one cycle
// after the grant and are routed to the requester that owned the grant.
//
// Optional feature: define MEM_ARBITER_STATS_EN to add three 32-bit wrapping
// counters (stat_if_grants, stat_d_grants, stat_if_stalls) as extra outputs.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  // instruction-fetch request/response
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_req_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_data,
  output logic        if_resp_fault,

  // load/store request/response
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [2:0]  d_req_op,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_resp_valid,
  output logic [31:0] d_resp_data,
  output logic        d_resp_fault,

  // shared memory port
  output logic [2:0]  mem_op,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_in,
  input  logic [31:0] mem_out,
  input  logic        mem_fault
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0] stat_if_grants,
  output logic [31:0] stat_d_grants,
  output logic [31:0] stat_if_stalls
`endif
);

  // Memory op encodings used by the arbiter itself.
  localparam logic [2:0] OP_LW      = 3'b010;  // fetch is always a word load
  localparam logic [2:0] OP_BADLOAD = 3'b011;  // faults in memory, never writes
  localparam logic [2:0] OP_IDLE    = 3'b000;  // harmless byte load at 0

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  // Arbitration state and decode
  logic [7:0] starve_cnt;
  logic [7:0] starve_cnt_next;
  logic       force_if;
  logic       grant_if;
  logic       grant_d;
  logic       grant_any;

  logic       d_is_store;
  logic [1:0] d_size;
  logic       d_misaligned;
  logic       d_suppress;

  // Response tracking registers
  logic       resp_valid_q;
  logic       resp_owner_q;   // 0 = fetch, 1 = data
  logic       resp_store_q;

  // Grant decision: data wins unless it is absent or fetch has starved.
  always_comb begin
    force_if  = if_req_valid && (starve_cnt == LIMIT);
    grant_if  = 1'b0;
    grant_d   = 1'b0;
    if (!reset) begin
      if (if_req_valid && (!d_req_valid || force_if)) begin
        grant_if = 1'b1;
      end else if (d_req_valid) begin
        grant_d = 1'b1;
      end
    end
    grant_any    = grant_if || grant_d;
    if_req_ready = grant_if;
    d_req_ready  = grant_d;
  end

  // Decode the data request to spot stores the memory would fault on.
  always_comb begin
    d_is_store   = d_req_op[2];
    d_size       = d_req_op[1:0];
    d_misaligned = 1'b0;
    case (d_size)
      SZ_HALF: d_misaligned = d_req_addr[0];
      SZ_WORD: d_misaligned = (d_req_addr[1:0] != 2'b00);
      default: d_misaligned = 1'b0;
    endcase
    d_suppress = d_is_store && ((d_size == SZ_BAD) || d_misaligned);
  end

  // Drive the shared memory port straight from the grant.
  always_comb begin
    mem_op   = OP_IDLE;
    mem_addr = 32'h0;
    mem_in   = 32'h0;
    if (grant_if) begin
      mem_op   = OP_LW;
      mem_addr = if_req_addr;
    end else if (grant_d) begin
      // A faulting store becomes an invalid load so nothing is written,
      // while the memory still reports the fault back to the requester.
      mem_op   = d_suppress ? OP_BADLOAD : d_req_op;
      mem_addr = d_req_addr;
      mem_in   = d_req_wdata;
    end
  end

  // Next starvation count: counts data wins over a waiting fetch, saturating.
  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!if_req_valid || grant_if) begin
      starve_cnt_next = 8'd0;
    end else if (grant_d && (starve_cnt != LIMIT)) begin
      starve_cnt_next = starve_cnt + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 8'd0;
    end else begin
      starve_cnt <= starve_cnt_next;
    end
  end

  // Remember who owns the access in flight so its result can be routed back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= 1'b0;
      resp_store_q <= 1'b0;
    end else begin
      resp_valid_q <= grant_any;
      resp_owner_q <= grant_d;
      resp_store_q <= grant_d && d_is_store;
    end
  end

  // Route the registered memory result to its owner; the other side reads 0.
  always_comb begin
    if_resp_valid = 1'b0;
    if_resp_data  = 32'h0;
    if_resp_fault = 1'b0;
    d_resp_valid  = 1'b0;
    d_resp_data   = 32'h0;
    d_resp_fault  = 1'b0;
    if (resp_valid_q) begin
      if (resp_owner_q) begin
        d_resp_valid = 1'b1;
        d_resp_fault = mem_fault;
        // Stores and faulting accesses return no data.
        d_resp_data  = (mem_fault || resp_store_q) ? 32'h0 : mem_out;
      end else begin
        if_resp_valid = 1'b1;
        if_resp_fault = mem_fault;
        if_resp_data  = mem_fault ? 32'h0 : mem_out;
      end
    end
  end

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] stat_if_grants_reg;
  logic [31:0] stat_d_grants_reg;
  logic [31:0] stat_if_stalls_reg;

  // Free-running wrapping counters of grants and fetch stall cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_if_grants_reg <= 32'h0;
      stat_d_grants_reg  <= 32'h0;
      stat_if_stalls_reg <= 32'h0;
    end else begin
      if (grant_if) begin
        stat_if_grants_reg <= stat_if_grants_reg + 32'h1;
      end
      if (grant_d) begin
        stat_d_grants_reg <= stat_d_grants_reg + 32'h1;
      end
      if (if_req_valid && !if_req_ready) begin
        stat_if_stalls_reg <= stat_if_stalls_reg + 32'h1;
      end
    end
  end

  assign stat_if_grants = stat_if_grants_reg;
  assign stat_d_grants  = stat_d_grants_reg;
  assign stat_if_stalls = stat_if_stalls_reg;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus randomized bench for mem_arbiter. A small
// byte-addressed memory sits on the shared port; it writes even on faulting
// stores, so only the arbiter's suppression keeps its contents intact. A
// reference model tracks expected grants, responses and memory contents.
module tb_mem_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_init;

  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_req_addr;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        if_resp_fault;
  logic        d_req_valid;
  logic        d_req_ready;
  logic [2:0]  d_req_op;
  logic [31:0] d_req_addr;
  logic [31:0] d_req_wdata;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        d_resp_fault;
  logic [2:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_in;
  logic [31:0] mem_out;
  logic        mem_fault;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] stat_if_grants;
  logic [31:0] stat_d_grants;
  logic [31:0] stat_if_stalls;
`endif

  mem_arbiter #(.STARVE_LIMIT(L)) dut (
    .clk           (clk),
    .reset         (reset),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .if_resp_fault (if_resp_fault),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_op      (d_req_op),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data),
    .d_resp_fault  (d_resp_fault),
    .mem_op        (mem_op),
    .mem_addr      (mem_addr),
    .mem_in        (mem_in),
    .mem_out       (mem_out),
    .mem_fault     (mem_fault)
`ifdef MEM_ARBITER_STATS_EN
    ,
    .stat_if_grants(stat_if_grants),
    .stat_d_grants (stat_d_grants),
    .stat_if_stalls(stat_if_stalls)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Initial memory image: a fixed pattern with the test-plan bytes placed.
  function automatic logic [7:0] init_byte(input int i);
    case (i)
      'h05:    return 8'hA5;
      'h10:    return 8'h44;
      'h11:    return 8'h33;
      'h12:    return 8'h22;
      'h13:    return 8'h11;
      default: return 8'((i * 29) ^ 'h5A);
    endcase
  endfunction

  function automatic logic [31:0] init_word(input int a);
    return {init_byte(a + 3), init_byte(a + 2), init_byte(a + 1), init_byte(a)};
  endfunction

  // An access faults if its size is invalid or its address is misaligned.
  function automatic logic acc_fault(input logic [2:0] op, input logic [31:0] a);
    case (op[1:0])
      2'b11:   return 1'b1;
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- memory on the shared port ----------------
  logic [7:0] env_mem [256];
  logic [7:0] ea;
  logic       env_bad;
  assign ea      = mem_addr[7:0];
  assign env_bad = acc_fault(mem_op, mem_addr);

  // Registered single-cycle memory; writes on any store op, even faulting ones.
  always @(posedge clk) begin
    mem_fault <= env_bad;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_byte(i);
      mem_out <= 32'h0;
    end else if (mem_op[2]) begin
      env_mem[ea] <= mem_in[7:0];
      if (mem_op[1:0] != 2'b00) env_mem[ea + 8'd1] <= mem_in[15:8];
      if (mem_op[1]) begin
        env_mem[ea + 8'd2] <= mem_in[23:16];
        env_mem[ea + 8'd3] <= mem_in[31:24];
      end
      mem_out <= 32'hCAFEF00D;
    end else if (env_bad) begin
      mem_out <= 32'hBAD0BAD0;
    end else begin
      case (mem_op[1:0])
        2'b00:   mem_out <= {24'h0, env_mem[ea]};
        2'b01:   mem_out <= {16'h0, env_mem[ea + 8'd1], env_mem[ea]};
        default: mem_out <= {env_mem[ea + 8'd3], env_mem[ea + 8'd2], env_mem[ea + 8'd1], env_mem[ea]};
      endcase
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [256];
  int         wait_d = 0;   // data wins since fetch started waiting
  logic       exp_if_v, exp_if_f, exp_d_v, exp_d_f;
  logic [31:0] exp_if_data, exp_d_data;
  logic       if_fire_q = 1'b0;
  logic       d_fire_q  = 1'b0;

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] a);
    logic [7:0] i;
    i = a[7:0];
    case (sz)
      2'b00:   return {24'h0, ref_mem[i]};
      2'b01:   return {16'h0, ref_mem[i + 8'd1], ref_mem[i]};
      default: return {ref_mem[i + 8'd3], ref_mem[i + 8'd2], ref_mem[i + 8'd1], ref_mem[i]};
    endcase
  endfunction

  // Expected grant: data first, unless absent or fetch has lost L times in a row.
  logic        m_g_if, m_g_d, m_sup;
  logic [2:0]  m_op;
  logic [31:0] m_addr, m_in;
  assign m_g_if = !reset && if_req_valid && (!d_req_valid || wait_d >= L);
  assign m_g_d  = !reset && d_req_valid && !m_g_if;
  assign m_sup  = d_req_op[2] && acc_fault(d_req_op, d_req_addr);
  assign m_op   = m_g_if ? 3'b010 : (m_g_d ? (m_sup ? 3'b011 : d_req_op) : 3'b000);
  assign m_addr = m_g_if ? if_req_addr : (m_g_d ? d_req_addr : 32'h0);
  assign m_in   = m_g_d ? d_req_wdata : 32'h0;

  // Compare every cycle at the falling edge, then advance the model.
  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) ref_mem[i] <= init_byte(i);
    end
    if (reset) begin
      check("if_resp_valid", {31'h0, if_resp_valid}, 32'h0);
      check("if_resp_data", if_resp_data, 32'h0);
      check("if_resp_fault", {31'h0, if_resp_fault}, 32'h0);
      check("d_resp_valid", {31'h0, d_resp_valid}, 32'h0);
      check("d_resp_data", d_resp_data, 32'h0);
      check("d_resp_fault", {31'h0, d_resp_fault}, 32'h0);
    end else begin
      check("if_resp_valid", {31'h0, if_resp_valid}, {31'h0, exp_if_v});
      check("if_resp_data", if_resp_data, exp_if_data);
      check("if_resp_fault", {31'h0, if_resp_fault}, {31'h0, exp_if_f});
      check("d_resp_valid", {31'h0, d_resp_valid}, {31'h0, exp_d_v});
      check("d_resp_data", d_resp_data, exp_d_data);
      check("d_resp_fault", {31'h0, d_resp_fault}, {31'h0, exp_d_f});
    end
    check("if_req_ready", {31'h0, if_req_ready}, {31'h0, m_g_if});
    check("d_req_ready", {31'h0, d_req_ready}, {31'h0, m_g_d});
    check("mem_op", {29'h0, mem_op}, {29'h0, m_op});
    check("mem_addr", mem_addr, m_addr);
    check("mem_in", mem_in, m_in);

    if_fire_q <= if_req_valid && if_req_ready;
    d_fire_q  <= d_req_valid && d_req_ready;

    exp_if_v    <= m_g_if;
    exp_if_f    <= m_g_if && acc_fault(3'b010, if_req_addr);
    exp_if_data <= (m_g_if && !acc_fault(3'b010, if_req_addr)) ? ref_load(2'b10, if_req_addr) : 32'h0;
    exp_d_v     <= m_g_d;
    exp_d_f     <= m_g_d && acc_fault(d_req_op, d_req_addr);
    exp_d_data  <= (m_g_d && !d_req_op[2] && !acc_fault(d_req_op, d_req_addr))
                   ? ref_load(d_req_op[1:0], d_req_addr) : 32'h0;

    if (reset || !if_req_valid || m_g_if) wait_d <= 0;
    else if (m_g_d && wait_d < L) wait_d <= wait_d + 1;

    // Only legal stores change memory.
    if (m_g_d && d_req_op[2] && !acc_fault(d_req_op, d_req_addr)) begin
      ref_mem[d_req_addr[7:0]] <= d_req_wdata[7:0];
      if (d_req_op[1:0] != 2'b00) ref_mem[d_req_addr[7:0] + 8'd1] <= d_req_wdata[15:8];
      if (d_req_op[1]) begin
        ref_mem[d_req_addr[7:0] + 8'd2] <= d_req_wdata[23:16];
        ref_mem[d_req_addr[7:0] + 8'd3] <= d_req_wdata[31:24];
      end
    end

    if (if_req_valid && if_req_ready)
      $display("txn t=%0t fetch addr=%h", $time, if_req_addr);
    if (d_req_valid && d_req_ready)
      $display("txn t=%0t data op=%b addr=%h wdata=%h", $time, d_req_op, d_req_addr, d_req_wdata);
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_if(input logic [31:0] a);
    bit done;
    done = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr  = a;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (if_fire_q) done = 1'b1;
    end
    if_req_valid = 1'b0;
    if (!done) check("if_handshake_timeout", 32'h0, 32'h1);
  endtask

  task automatic send_d(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    bit done;
    done = 1'b0;
    d_req_valid = 1'b1;
    d_req_op    = op;
    d_req_addr  = a;
    d_req_wdata = wd;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (d_fire_q) done = 1'b1;
    end
    d_req_valid = 1'b0;
    if (!done) check("d_handshake_timeout", 32'h0, 32'h1);
  endtask

  // Issue a data access and check its response against literal values.
  task automatic d_chk(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_fault);
    send_d(op, a, wd);
    @(negedge clk);
    check({tag, "_valid"}, {31'h0, d_resp_valid}, 32'h1);
    check({tag, "_data"}, d_resp_data, exp_data);
    check({tag, "_fault"}, {31'h0, d_resp_fault}, {31'h0, exp_fault});
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dcnt;
    int seen_if;

    reset        = 1'b1;
    mem_init     = 1'b1;
    if_req_valid = 1'b1;
    if_req_addr  = 32'h10;
    d_req_valid  = 1'b1;
    d_req_op     = 3'b010;
    d_req_addr   = 32'h20;
    d_req_wdata  = 32'h0;

    // Nothing is accepted and all responses read 0 while reset is high.
    @(negedge clk);
    check("rst_if_ready", {31'h0, if_req_ready}, 32'h0);
    check("rst_d_ready", {31'h0, d_req_ready}, 32'h0);
    check("rst_if_resp_valid", {31'h0, if_resp_valid}, 32'h0);
    check("rst_d_resp_valid", {31'h0, d_resp_valid}, 32'h0);
    step();
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    step();
    step();
    mem_init = 1'b0;
    reset    = 1'b0;
    step();

    // Fetch from 0x10 returns the preloaded word next cycle.
    send_if(32'h10);
    @(negedge clk);
    check("fetch_valid", {31'h0, if_resp_valid}, 32'h1);
    check("fetch_data", if_resp_data, 32'h11223344);
    check("fetch_fault", {31'h0, if_resp_fault}, 32'h0);
    check("fetch_d_quiet", {31'h0, d_resp_valid}, 32'h0);
    step();

    // Misaligned SW is suppressed; the following LW sees unchanged memory.
    d_chk("sw_mis", 3'b110, 32'h22, 32'hDEADBEEF, 32'h0, 1'b1);
    d_chk("lw_after", 3'b010, 32'h20, 32'h0, init_word('h20), 1'b0);

    // LB then SH back to back, then read the halfword bytes back.
    send_d(3'b000, 32'h05, 32'h0);
    send_d(3'b101, 32'h06, 32'h1234);
    @(negedge clk);
    check("sh_valid", {31'h0, d_resp_valid}, 32'h1);
    check("sh_data", d_resp_data, 32'h0);
    check("sh_fault", {31'h0, d_resp_fault}, 32'h0);
    step();
    d_chk("lb06", 3'b000, 32'h06, 32'h0, 32'h34, 1'b0);
    d_chk("lb07", 3'b000, 32'h07, 32'h0, 32'h12, 1'b0);
    d_chk("lb05", 3'b000, 32'h05, 32'h0, 32'hA5, 1'b0);

    // Invalid-size store faults and leaves the word untouched.
    d_chk("op111", 3'b111, 32'h40, 32'hFFFFFFFF, 32'h0, 1'b1);
    d_chk("lw40", 3'b010, 32'h40, 32'h0, init_word('h40), 1'b0);

    // Continuous contention: fetch wins once every L+1 cycles.
    if_req_valid = 1'b1;
    if_req_addr  = 32'h10;
    d_req_valid  = 1'b1;
    d_req_op     = 3'b010;
    d_req_addr   = 32'h20;
    dcnt    = 0;
    seen_if = 0;
    for (int k = 0; k < 2 * (L + 1); k++) begin
      step();
      if (d_fire_q) dcnt++;
      if (if_fire_q) begin
        check("starve_run", dcnt, L);
        seen_if++;
        dcnt = 0;
      end
    end
    check("starve_if_grants", seen_if, 2);
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    step();

    // Reset while a data response is pending drops it and clears starvation.
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    d_req_op     = 3'b010;
    d_req_addr   = 32'h10;
    step();
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rst_pulse_d_valid", {31'h0, d_resp_valid}, 32'h0);
    check("rst_pulse_if_valid", {31'h0, if_resp_valid}, 32'h0);
    step();
    check("rst_pulse_starve", {24'h0, dut.starve_cnt}, 32'h0);
    reset = 1'b0;
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    step();

    // Randomized traffic checked by the reference model every cycle.
    for (int c = 0; c < 600; c++) begin
      step();
      if (!if_req_valid || if_fire_q) begin
        if ($urandom_range(0, 9) < 6) begin
          if_req_valid = 1'b1;
          if_req_addr  = $urandom;
          if ($urandom_range(0, 9) != 0) if_req_addr[1:0] = 2'b00;
        end else begin
          if_req_valid = 1'b0;
        end
      end
      if (!d_req_valid || d_fire_q) begin
        if ($urandom_range(0, 9) < 7) begin
          d_req_valid = 1'b1;
          d_req_op    = 3'($urandom_range(0, 7));
          d_req_addr  = $urandom;
          d_req_wdata = $urandom;
          if ($urandom_range(0, 1) == 1) begin
            if (d_req_op[1:0] == 2'b01) d_req_addr[0] = 1'b0;
            if (d_req_op[1:0] == 2'b10) d_req_addr[1:0] = 2'b00;
          end
        end else begin
          d_req_valid = 1'b0;
        end
      end
    end
    if_req_valid = 1'b0;
    d_req_valid  = 1'b0;
    step();
    step();
    step();

    // Memory contents must match the model: no faulting store ever landed.
    for (int i = 0; i < 256; i++) begin
      check($sformatf("mem_byte_%02h", i), {24'h0, env_mem[i]}, {24'h0, ref_mem[i]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
